// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: shares the 8-digit seven-segment display among NREQ requesters,
// switching owners round-robin only at scan-frame boundaries with a minimum hold.
module seg_display_arbiter #(
  parameter int          NREQ        = 4,
  parameter int          SCAN_DIV    = 50000,
  parameter int          HOLD_FRAMES = 64,
  parameter logic [31:0] IDLE_DATA   = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [32*NREQ-1:0] data_in,
  output logic [NREQ-1:0]    gnt,
  output logic               busy,
  output logic [31:0]        disp_data,
  output logic               scan_en,
  output logic [2:0]         digit_idx
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int HW = HOLD_FRAMES > 1 ? $clog2(HOLD_FRAMES) : 1;
  typedef enum logic {IDLE, OWN} state_t;
  state_t              state;
  logic [CW-1:0]       pre;
  logic [PW-1:0]       ptr, own, off, win, nxt;
  logic [HW-1:0]       hold;
  logic [NREQ-1:0]     cand;
  logic [2*NREQ-1:0]   rot;
  logic [PW:0]         sum;
  logic [31:0]         sel;
  logic                frame_end;
  assign frame_end = scan_en && digit_idx == 3'd7;
  assign busy = state == OWN;
  // The current owner is masked so a hand-over only considers the others.
  assign cand = (state == OWN) ? req & ~gnt : req;
  assign rot = {cand, cand} >> ptr;
  always_comb begin
    off = '0;
    for (int i = NREQ-1; i >= 0; i--) if (rot[i]) off = PW'(i);
  end
  assign sum = {1'b0, ptr} + {1'b0, off};
  assign win = PW'(sum >= (PW+1)'(NREQ) ? sum - (PW+1)'(NREQ) : sum);
  assign nxt = (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
  always_comb begin
    sel = data_in[31:0];
    for (int i = 0; i < NREQ; i++) if (own == PW'(i)) sel = data_in[32*i +: 32];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre       <= '0;
      scan_en   <= 1'b0;
      digit_idx <= '0;
      state     <= IDLE;
      ptr       <= '0;
      own       <= '0;
      hold      <= '0;
      gnt       <= '0;
      disp_data <= IDLE_DATA;
    end else begin
      pre       <= (pre == CW'(SCAN_DIV-1)) ? '0 : pre + 1'b1;
      scan_en   <= pre == CW'(SCAN_DIV-1);
      digit_idx <= scan_en ? digit_idx + 3'd1 : digit_idx;
      disp_data <= (state == OWN) ? sel : IDLE_DATA;
      if (frame_end) begin
        if (state == OWN && hold != '0) begin
          hold <= hold - 1'b1;
        end else if (|cand) begin
          state <= OWN;
          own   <= win;
          gnt   <= NREQ'(1) << win;
          hold  <= HW'(HOLD_FRAMES-1);
          ptr   <= nxt;
        end else if (state == OWN && !req[own]) begin
          state <= IDLE;
          gnt   <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb_seg_display_arbiter: directed test-plan scenarios plus randomized traffic, all
// checked every cycle against an edge-counting behavioural model of the arbiter.
module tb_seg_display_arbiter;
  localparam int NREQ = 4, SCAN_DIV = 4, HOLD = 2, FRAME = 8 * SCAN_DIV;
  logic              clk = 0, rst_n = 0;
  logic [NREQ-1:0]   req = '0;
  logic [32*NREQ-1:0] data_in = '0;
  logic [NREQ-1:0]   gnt;
  logic              busy, scan_en;
  logic [31:0]       disp_data;
  logic [2:0]        digit_idx;
  int checks = 0, failures = 0;
  int e = 0, m_own = -1, m_hold = 0, m_ptr = 0;
  logic [31:0] m_disp = 0;

  seg_display_arbiter #(.NREQ(NREQ), .SCAN_DIV(SCAN_DIV), .HOLD_FRAMES(HOLD),
    .IDLE_DATA(32'h0)) dut (.clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in),
    .gnt(gnt), .busy(busy), .disp_data(disp_data), .scan_en(scan_en), .digit_idx(digit_idx));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, e, act, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r, input int from);
    for (int i = 0; i < NREQ; i++) if (r[(from + i) % NREQ]) return (from + i) % NREQ;
    return -1;
  endfunction

  // Model: edges counted from reset release; frames end on edges 33, 65, ...
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      e = 0; m_own = -1; m_hold = 0; m_ptr = 0; m_disp = 0;
    end else begin
      logic [NREQ-1:0] others;
      int w;
      e++;
      m_disp = (m_own >= 0) ? data_in[32*m_own +: 32] : 32'h0;
      if (e > 1 && (e - 1) % FRAME == 0) begin
        others = (m_own >= 0) ? req & ~(NREQ'(1) << m_own) : req;
        if (m_own >= 0 && m_hold > 0) m_hold--;
        else if (others != 0) begin
          w = pick(others, m_ptr);
          m_own = w; m_hold = HOLD - 1; m_ptr = (w + 1) % NREQ;
        end else if (m_own >= 0 && !req[m_own]) m_own = -1;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    chk("scan_en", 32'(scan_en), 32'(e > 0 && e % SCAN_DIV == 0));
    chk("digit_idx", 32'(digit_idx), 32'(e > 0 ? ((e - 1) / SCAN_DIV) % 8 : 0));
    chk("gnt", 32'(gnt), m_own >= 0 ? 32'(1) << m_own : 32'h0);
    chk("busy", 32'(busy), 32'(m_own >= 0));
    chk("disp_data", disp_data, m_disp);
  end

  task automatic at_edge(input int n);
    while (e < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    req = '0; data_in = '0;
    do_reset();
    at_edge(3);  chk("lit_scan_e3", 32'(scan_en), 0);
    at_edge(4);  chk("lit_scan_e4", 32'(scan_en), 1);
    req = 4'b0010; data_in[63:32] = 32'h1234_5678;
    at_edge(32); chk("lit_gnt_e32", 32'(gnt), 0);
    at_edge(33); chk("lit_gnt_e33", 32'(gnt), 32'b0010); chk("lit_busy_e33", 32'(busy), 1);
    at_edge(34); chk("lit_disp_e34", disp_data, 32'h1234_5678);
    data_in[63:32] = 32'hCAFE_0001;
    at_edge(35); chk("lit_disp_e35", disp_data, 32'hCAFE_0001);

    req = 4'b0101; data_in = {32'h3, 32'hC2, 32'h1, 32'hA0};
    do_reset();
    at_edge(33);  chk("lit_rr_e33", 32'(gnt), 32'b0001);
    at_edge(34);  chk("lit_rr_disp_e34", disp_data, 32'hA0);
    at_edge(97);  chk("lit_rr_e97", 32'(gnt), 32'b0100);
    at_edge(98);  chk("lit_rr_disp_e98", disp_data, 32'hC2);
    at_edge(161); chk("lit_rr_e161", 32'(gnt), 32'b0001);

    req = 4'b1000;
    do_reset();
    at_edge(39); req = '0;
    at_edge(96); chk("lit_drop_e96", 32'(gnt), 32'b1000);
    at_edge(97); chk("lit_drop_e97", 32'(gnt), 0); chk("lit_drop_disp_e97", disp_data, 32'h3);
    at_edge(98); chk("lit_drop_disp_e98", disp_data, 0);

    req = 4'b0001;
    do_reset();
    at_edge(97);  chk("lit_keep_e97", 32'(gnt), 32'b0001);
    at_edge(129); chk("lit_keep_e129", 32'(gnt), 32'b0001);
    req = 4'b0011;
    at_edge(160); chk("lit_keep_e160", 32'(gnt), 32'b0001);
    at_edge(161); chk("lit_switch_e161", 32'(gnt), 32'b0010);

    req = 4'b0001;
    do_reset();
    at_edge(50);
    #2 rst_n = 0;
    #1;
    chk("lit_arst_gnt", 32'(gnt), 0); chk("lit_arst_scan", 32'(scan_en), 0);
    chk("lit_arst_digit", 32'(digit_idx), 0); chk("lit_arst_disp", disp_data, 0);
    chk("lit_arst_busy", 32'(busy), 0);
    @(negedge clk) rst_n = 1;
    at_edge(3); chk("lit_arst_scan_e3", 32'(scan_en), 0);
    at_edge(4); chk("lit_arst_scan_e4", 32'(scan_en), 1);

    for (int c = 0; c < 6000; c++) begin
      @(posedge clk);
      #2;
      if ($urandom_range(0, 29) == 0)
        req = ($urandom_range(0, 2) == 0) ? NREQ'(1) << $urandom_range(0, NREQ-1)
                                          : NREQ'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) data_in[32*$urandom_range(0, NREQ-1) +: 32] = $urandom;
      if ($urandom_range(0, 999) == 0) begin
        #1 rst_n = 0;
        @(negedge clk) rst_n = 1;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
- Shares the 8-digit seven-segment display among NREQ requesters, each of which presents its own 32-bit value, e.g. PC, register file readout or memory data.
- Generates the scan-rate enable for the downstream display scanner.
- Grants ownership round-robin; ownership changes only at scan-frame boundaries, so a frame never mixes digits from two sources.
- Each owner is held for a minimum of HOLD_FRAMES frames.

Parameters:
- NREQ, 4, number of requesters; must be >= 2.
- SCAN_DIV, 50000, clk cycles per scan_en pulse; must be >= 2.
- HOLD_FRAMES, 64, minimum number of frames an owner keeps the grant; must be >= 1.
- IDLE_DATA, 32'h0000_0000, value shown when no requester owns the display.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  NREQ  request vector; level-sensitive, held high while display wanted.
- data_in  in  32*NREQ  requester values; requester i occupies bits [32*i+31:32*i].
- gnt  out  NREQ  one-hot grant; all zero when idle.
- busy  out  1  high while any grant is active.
- disp_data  out  32  value for the display scanner.
- scan_en  out  1  one-cycle scan-advance pulse.
- digit_idx  out  3  current digit index 0..7; wraps with the frame.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. All registers clear immediately when rst_n is asserted, including mid-frame or mid-grant:
  - gnt=0, busy=0, scan_en=0, digit_idx=0, disp_data=IDLE_DATA
  - prescaler=0, RR pointer=0, hold counter=0, state IDLE.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - Registered scan_en goes high for exactly one cycle after each wrap, i.e. after rising edges SCAN_DIV, 2*SCAN_DIV, ... (edges numbered from 1 after reset release).
  - Free-running; independent of requests.
- Digit counter: digit_idx increments, wrapping 7->0, on each edge where scan_en=1.
- frame_end (internal): scan_en=1 and digit_idx=7. All arbitration decisions are taken only on the edge where frame_end=1.
- FSM IDLE:
  - If req==0, stay.
  - Else grant the first set req bit searching upward from ptr, modulo NREQ.
  - Load hold counter with HOLD_FRAMES-1, set ptr=winner+1 mod NREQ, go OWN.
- FSM OWN (owner k), at each frame_end:
  - If hold>0: hold decrements; grant kept regardless of req[k].
  - If hold==0 and req[k]=1 and no other req: keep the grant; hold stays 0.
  - If hold==0 and some other req is set: grant the first set bit searching from ptr with bit k masked; reload hold; update ptr.
  - If hold==0 and req==0 (only possible with req[k]=0): go IDLE, gnt=0.
- busy: equals (state==OWN).
- disp_data:
  - OWN: registered copy of owner's data_in slice, refreshed every cycle.
  - IDLE: IDLE_DATA.
  - Latency: gnt changes at edge E; disp_data reflects the new source at edge E+1.
- An owner that drops req mid-hold stays granted; disp_data keeps tracking its data_in slice.
- ptr width is clog2(NREQ); increment wraps modulo NREQ, including for non-power-of-2 NREQ.

Test Plan (SCAN_DIV=4, HOLD_FRAMES=2, NREQ=4, IDLE_DATA=0; frame = 32 cycles):
- Release reset, req=0 -> scan_en high after edges 4, 8, 12, ...; digit_idx steps 0..7 and wraps; gnt=0, busy=0, disp_data=0 throughout.
- req=4'b0010 from edge 5, data_in[63:32]=32'h1234_5678 -> gnt=0010 and busy=1 after edge 33; disp_data=32'h1234_5678 after edge 34; data change to 32'hCAFE_0001 appears one cycle later.
- req=4'b0101 held, ptr=0 -> gnt=0001 after edge 33; 0100 after edge 97 (two frames later); 0001 after edge 161; disp_data alternates with the sources one cycle after each gnt change.
- req=4'b1000 granted after edge 33; req dropped at edge 40 -> gnt stays 1000 through edge 96, returns to 0 after edge 97; disp_data=0 after edge 98.
- gnt=0001 active, rst_n pulsed low at edge 50 (mid-frame) -> gnt=0, scan_en=0, digit_idx=0, disp_data=0 immediately; after release the first scan_en follows edge 4.
- Owner req=0001 alone past hold expiry -> grant retained at every frame_end; req 0010 added -> switch to 0010 at the next frame_end.
